game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Game-level FSM: consumes bomberman/enemy overlap (death_signal) and enemy-kill pulses; tracks lives and score.
//  Produces game_over (drives the VGA mixer's green full-screen override) and a respawn pulse to bomberman.
//  Also produces invulnerability/flash control so bomberman blinks after a hit. Sits between enemy/bomberman and the mixer.
// PARAMETERS
//  LIVES_INIT     3            lives at reset; legal 1..3 (2-bit counter)
//  INVULN_CYCLES  100_000_000  post-hit invulnerability length in clk cycles (1 s @100 MHz)
//  CNT_W          27           width of invulnerability down-counter; must hold INVULN_CYCLES-1
//  FLASH_FRAMES   4            frame_ticks per blink half-period during invulnerability
//  SCORE_W        8            score counter width
// PORTS
//  clk              in   1        system clock, 100 MHz
//  reset            in   1        synchronous, active-high
//  start            in   1        level; OR of raw movement buttons; leaves IDLE
//  death_signal     in   1        level; OR of all enemy overlap flags
//  kill_pulse       in   1        1-cycle pulse per enemy destroyed by explosion
//  frame_tick       in   1        1-cycle pulse per VGA frame (vc wrap)
//  game_over        out  1        high in OVER
//  playing          out  1        high in PLAY or HIT
//  lives            out  2        remaining lives
//  score            out  SCORE_W  enemies killed, saturating
//  invuln           out  1        high in HIT
//  respawn          out  1        1-cycle pulse: bomberman returns to start tile
//  blank_bomberman  out  1        mixer suppresses bomberman_rgb_en while high
// BEHAVIOUR
//  All outputs registered; each responds 1 cycle after the input sample that causes it.
//  Reset (sync): state=IDLE, lives=LIVES_INIT, score=0, timer=0, flash count=0, all 1-bit outputs 0.
//  Reset mid-game returns to IDLE from any state, including OVER.
//  IDLE: death_signal and kill_pulse ignored; start=1 -> PLAY.
//  PLAY, death_signal=1:
//    lives>1: lives-=1, respawn=1 for one cycle, timer<=INVULN_CYCLES-1, -> HIT.
//    lives==1: lives<=0, -> OVER, no respawn.
//  HIT: death_signal ignored; timer decrements each cycle; when timer==0 -> PLAY.
//    If death_signal is still high on entry to PLAY, a further life is taken next cycle.
//  HIT flash: flash counter counts frame_ticks. Every FLASH_FRAMES ticks, blank_bomberman toggles.
//    blank_bomberman is forced 0 outside HIT; counter clears on entry to HIT.
//  OVER: sticky until reset; game_over=1, playing=0; all inputs ignored.
//  Score: kill_pulse in PLAY/HIT -> score+1, saturating at 2^SCORE_W-1; ignored in IDLE/OVER.
//  Simultaneous kill_pulse and death_signal in PLAY: both applied in the same cycle (score+1 and life lost).
//  Simultaneous start and death_signal in IDLE: -> PLAY only; death is evaluated from next cycle.
//  lives never underflows; decrement occurs only on the PLAY branch above.
// STRUCTURE
//  Shared package game_pkg holds:
//    state encoding IDLE=2'd0, PLAY=2'd1, HIT=2'd2, OVER=2'd3
//    LIVES_W=2 and the VGA bounds MIN_X/MAX_X/MIN_Y/MAX_Y/T_SIZE (shared with top and enemy).
//  One sub-module: invuln_timer.
//    Ports: clk, reset, load, load_val[CNT_W], done.
//    Down-counter; done is high when count==0.
//  FSM, lives, score and flash logic stay in this module.
// TESTING
//  1. reset; start=1 for 1 cycle; death_signal=1 for 1 cycle
//     -> lives 3->2, respawn pulse exactly 1 cycle, invuln=1, game_over=0.
//  2. INVULN_CYCLES=10: hold death_signal=1 for 30 cycles from PLAY
//     -> lives 3->2, then 1 at cycle ~11, then 0 with game_over=1 at cycle ~22; no respawn on the last hit.
//  3. In OVER: pulse kill_pulse x5, start, death_signal
//     -> score, lives, game_over unchanged; reset -> IDLE, lives=3, score=0, game_over=0.
//  4. SCORE_W=3: 9 kill_pulses in PLAY -> score 7 (saturated).
//     kill_pulse in IDLE -> score stays 0.
//  5. FLASH_FRAMES=2, HIT for 8 frame_ticks -> blank_bomberman toggles every 2 ticks (4 toggles).
//     Forced 0 on return to PLAY.
//  6. PLAY: kill_pulse and death_signal same cycle -> score+1 and lives-1 next cycle; reset asserted mid-HIT -> IDLE next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, lives width and playfield bounds
// used by the game controller, the top-level and the enemy logic.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StHit  = 2'd2,
    StOver = 2'd3
  } state_e;

  localparam int unsigned LIVES_W = 2;

  // Playfield bounds in pixels and tile size, shared with the renderer and enemies.
  localparam int unsigned MIN_X  = 0;
  localparam int unsigned MAX_X  = 639;
  localparam int unsigned MIN_Y  = 0;
  localparam int unsigned MAX_Y  = 479;
  localparam int unsigned T_SIZE = 32;

  // True while a round is in progress (bomberman alive or recovering from a hit).
  function automatic logic is_active(input state_e s);
    return (s == StPlay) || (s == StHit);
  endfunction

endpackage

// File: rtl/invuln_timer.sv
// Post-hit invulnerability down-counter. Loads on request, counts down to zero
// and parks there; done flags the parked state.
module invuln_timer #(
  parameter int unsigned CNT_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// Game-level controller: tracks lives and score, sequences IDLE/PLAY/HIT/OVER,
// and drives respawn, invulnerability and blink control for bomberman.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_CYCLES = 100_000_000,
  parameter int unsigned CNT_W         = 27,
  parameter int unsigned FLASH_FRAMES  = 4,
  parameter int unsigned SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               death_signal,
  input  logic               kill_pulse,
  input  logic               frame_tick,
  output logic               game_over,
  output logic               playing,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               invuln,
  output logic               respawn,
  output logic               blank_bomberman
);

  localparam int unsigned FlashW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  state_e state_d, state_q;

  logic [LIVES_W-1:0] lives_d, lives_q;
  logic [SCORE_W-1:0] score_d, score_q;
  logic [FlashW-1:0]  flash_d, flash_q;
  logic               blank_d, blank_q;
  logic               respawn_d, respawn_q;
  logic               invuln_d, invuln_q;
  logic               playing_d, playing_q;
  logic               game_over_d, game_over_q;

  logic timer_load;
  logic timer_done;

  invuln_timer #(
    .CNT_W(CNT_W)
  ) u_invuln_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .load_val(CNT_W'(INVULN_CYCLES - 1)),
    .done    (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    respawn_d  = 1'b0;
    timer_load = 1'b0;

    case (state_q)
      StIdle: begin
        // Death in the same cycle as start is deliberately not seen until PLAY.
        if (start) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (death_signal) begin
          if (lives_q > LIVES_W'(1)) begin
            lives_d    = lives_q - LIVES_W'(1);
            respawn_d  = 1'b1;
            timer_load = 1'b1;
            state_d    = StHit;
          end else begin
            lives_d = '0;
            state_d = StOver;
          end
        end
      end
      StHit: begin
        if (timer_done) begin
          state_d = StPlay;
        end
      end
      StOver: begin
        state_d = StOver;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    score_d = score_q;
    if (is_active(state_q) && kill_pulse && (score_q != '1)) begin
      score_d = score_q + SCORE_W'(1);
    end
  end

  // Blink counter only runs while staying in HIT; entry and exit both clear it.
  always_comb begin
    flash_d = '0;
    blank_d = 1'b0;
    if ((state_q == StHit) && (state_d == StHit)) begin
      flash_d = flash_q;
      blank_d = blank_q;
      if (frame_tick) begin
        if (flash_q == FlashW'(FLASH_FRAMES - 1)) begin
          flash_d = '0;
          blank_d = ~blank_q;
        end else begin
          flash_d = flash_q + FlashW'(1);
        end
      end
    end
  end

  always_comb begin
    invuln_d    = (state_d == StHit);
    playing_d   = is_active(state_d);
    game_over_d = (state_d == StOver);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      lives_q     <= LIVES_W'(LIVES_INIT);
      score_q     <= '0;
      flash_q     <= '0;
      blank_q     <= 1'b0;
      respawn_q   <= 1'b0;
      invuln_q    <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      flash_q     <= flash_d;
      blank_q     <= blank_d;
      respawn_q   <= respawn_d;
      invuln_q    <= invuln_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  assign game_over       = game_over_q;
  assign playing         = playing_q;
  assign lives           = lives_q;
  assign score           = score_q;
  assign invuln          = invuln_q;
  assign respawn         = respawn_q;
  assign blank_bomberman = blank_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: a per-cycle vector table plus hand-written
// sequences for repeated hits, OVER stickiness, score saturation and blinking.
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       death_signal = 1'b0;
  logic       kill_pulse = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_over;
  logic       playing;
  logic [1:0] lives;
  logic [2:0] score;
  logic       invuln;
  logic       respawn;
  logic       blank_bomberman;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_state_ctrl #(
    .LIVES_INIT   (3),
    .INVULN_CYCLES(10),
    .CNT_W        (4),
    .FLASH_FRAMES (2),
    .SCORE_W      (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .death_signal   (death_signal),
    .kill_pulse     (kill_pulse),
    .frame_tick     (frame_tick),
    .game_over      (game_over),
    .playing        (playing),
    .lives          (lives),
    .score          (score),
    .invuln         (invuln),
    .respawn        (respawn),
    .blank_bomberman(blank_bomberman)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic       death;
    logic       kill;
    logic       tick;
    logic       e_over;
    logic       e_play;
    logic [1:0] e_lives;
    logic [2:0] e_score;
    logic       e_inv;
    logic       e_resp;
    logic       e_blank;
  } vec_t;

  localparam int NVec = 10;
  vec_t vecs[NVec];

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic d, input logic k,
                       input logic t);
    reset        = r;
    start        = s;
    death_signal = d;
    kill_pulse   = k;
    frame_tick   = t;
  endtask

  initial begin
    int toggles;
    logic prev_blank;
    int waited;

    //            rst  st   dth  kill tick  over play lives score inv  resp blank
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'd1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].death, vecs[i].kill, vecs[i].tick);
      step();
      chk("vec.game_over", i, game_over, vecs[i].e_over);
      chk("vec.playing", i, playing, vecs[i].e_play);
      chk("vec.lives", i, lives, vecs[i].e_lives);
      chk("vec.score", i, score, vecs[i].e_score);
      chk("vec.invuln", i, invuln, vecs[i].e_inv);
      chk("vec.respawn", i, respawn, vecs[i].e_resp);
      chk("vec.blank", i, blank_bomberman, vecs[i].e_blank);
    end

    // Held death: hits land at edges 1 and 12, game over at edge 23.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      step();
      chk("hold.lives", k, lives, (k < 12) ? 2'd2 : (k < 23) ? 2'd1 : 2'd0);
      chk("hold.game_over", k, game_over, k >= 23);
      chk("hold.respawn", k, respawn, (k == 1) || (k == 12));
      chk("hold.invuln", k, invuln, ((k >= 1) && (k <= 10)) || ((k >= 12) && (k <= 21)));
      chk("hold.playing", k, playing, k < 23);
    end

    // OVER ignores every input.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, k[0], k[1], 1'b1, 1'b1);
      step();
      chk("over.game_over", k, game_over, 1'b1);
      chk("over.lives", k, lives, 2'd0);
      chk("over.score", k, score, 3'd0);
      chk("over.playing", k, playing, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("over_rst.game_over", 0, game_over, 1'b0);
    chk("over_rst.lives", 0, lives, 2'd3);
    chk("over_rst.score", 0, score, 3'd0);
    chk("over_rst.playing", 0, playing, 1'b0);

    // Score saturates at 7 with a 3-bit counter.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("sat.score", k, score, (k > 7) ? 3'd7 : 3'(k));
    end

    // Blink: 8 back-to-back frame ticks in HIT give 4 toggles.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("flash.entry_invuln", 0, invuln, 1'b1);
    chk("flash.entry_blank", 0, blank_bomberman, 1'b0);
    toggles    = 0;
    prev_blank = blank_bomberman;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("flash.blank", i, blank_bomberman, ((i / 2) % 2) == 1);
      if (blank_bomberman !== prev_blank) toggles++;
      prev_blank = blank_bomberman;
    end
    chk("flash.toggles", 0, toggles, 4);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waited = 0;
    while (invuln === 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    chk("flash.exit_invuln", 0, invuln, 1'b0);
    chk("flash.exit_playing", 0, playing, 1'b1);
    chk("flash.exit_blank", 0, blank_bomberman, 1'b0);

    // Leave HIT while blanked: output must drop to 0 in PLAY.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("force.lives", 0, lives, 2'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    chk("force.blank_hit", 0, blank_bomberman, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waited = 0;
    while (invuln === 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    chk("force.exit_invuln", 0, invuln, 1'b0);
    chk("force.exit_playing", 0, playing, 1'b1);
    chk("force.exit_blank", 0, blank_bomberman, 1'b0);
    chk("force.lives_kept", 0, lives, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
